// File: rtl/arm_imm_encoder.sv
// Iterative encoder for the ARM rotated-immediate operand: finds the lowest
// rotation giving {rot, imm8} with ROR(imm8, 2*rot) == VALUE (or ~VALUE).
module arm_imm_encoder (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [31:0] VALUE,
   input  logic        TRY_INV,
   output logic        BUSY,
   output logic        DONE,
   output logic        FOUND,
   output logic        INVERTED,
   output logic [11:0] IMM12
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ROT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [ROT_W-1:0]    rot, rot_n;
   logic                inv, inv_n;
   logic                try_inv_q, try_inv_n;
   logic [DATA_W-1:0]   val_q, val_n;
   logic                busy_n, done_n, found_n, inverted_n;
   logic [11:0]         imm12_n;

   logic [DATA_W-1:0]   src;
   logic [2*DATA_W-1:0] dbl;
   logic [DATA_W-1:0]   cand;
   logic [4:0]          shamt;

   // Candidate = ROL(src, 2*rot); upper half of the doubled word shifted left.
   always_comb begin
      src   = inv ? ~val_q : val_q;
      shamt = {rot, 1'b0};
      dbl   = {src, src} << shamt;
      cand  = dbl[2*DATA_W-1:DATA_W];
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_n    = state;
      rot_n      = rot;
      inv_n      = inv;
      try_inv_n  = try_inv_q;
      val_n      = val_q;
      done_n     = 1'b0;
      found_n    = FOUND;
      inverted_n = INVERTED;
      imm12_n    = IMM12;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_n    = ST_SEARCH;
               val_n      = VALUE;
               try_inv_n  = TRY_INV;
               rot_n      = '0;
               inv_n      = 1'b0;
               found_n    = 1'b0;
               inverted_n = 1'b0;
               imm12_n    = '0;
            end else if (state == ST_DONE) begin
               state_n = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            if (cand[DATA_W-1:8] == '0) begin
               state_n    = ST_DONE;
               done_n     = 1'b1;
               found_n    = 1'b1;
               inverted_n = inv;
               imm12_n    = {rot, cand[7:0]};
            end else if (rot != 4'd15) begin
               rot_n = rot + 4'd1;
            end else if (!inv && try_inv_q) begin
               inv_n = 1'b1;
               rot_n = '0;
            end else begin
               state_n    = ST_DONE;
               done_n     = 1'b1;
               found_n    = 1'b0;
               inverted_n = 1'b0;
               imm12_n    = '0;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      busy_n = (state_n == ST_SEARCH);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         rot       <= '0;
         inv       <= 1'b0;
         try_inv_q <= 1'b0;
         val_q     <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         FOUND     <= 1'b0;
         INVERTED  <= 1'b0;
         IMM12     <= '0;
      end else begin
         state     <= state_n;
         rot       <= rot_n;
         inv       <= inv_n;
         try_inv_q <= try_inv_n;
         val_q     <= val_n;
         BUSY      <= busy_n;
         DONE      <= done_n;
         FOUND     <= found_n;
         INVERTED  <= inverted_n;
         IMM12     <= imm12_n;
      end
   end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed and swept checks of arm_imm_encoder latency, result and priority.
module tb_arm_imm_encoder;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [31:0] VALUE = '0;
   logic        TRY_INV = 1'b0;
   logic        BUSY, DONE, FOUND, INVERTED;
   logic [11:0] IMM12;

   int vectors = 0;
   int miscompares = 0;

   arm_imm_encoder dut (
      .CLK(CLK), .RST(RST), .START(START), .VALUE(VALUE), .TRY_INV(TRY_INV),
      .BUSY(BUSY), .DONE(DONE), .FOUND(FOUND), .INVERTED(INVERTED), .IMM12(IMM12)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[i] = x[(i + n) % 32];
      return y;
   endfunction

   // Reference: {found, inverted, imm12}, lowest rotation first, direct before inverted.
   function automatic logic [13:0] ref_encode(input logic [31:0] v, input logic t);
      logic [31:0] x;
      logic [7:0]  imm8;
      for (int k = 0; k < 2; k++) begin
         if (k == 1 && !t) break;
         x = (k == 1) ? ~v : v;
         for (int r = 0; r < 16; r++) begin
            imm8 = ror32(x, (32 - 2 * r) % 32) ;
            if (ror32({24'h0, imm8}, 2 * r) == x)
               return {1'b1, (k == 1), 4'(r), imm8};
         end
      end
      return 14'h0;
   endfunction

   // Issue one request; lat is the edge index at which DONE was first seen (40 = timeout).
   task automatic do_req(input logic [31:0] v, input logic t, output int lat, output int busy_cnt);
      @(negedge CLK);
      VALUE = v; TRY_INV = t; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      lat = 0; busy_cnt = 0;
      while (lat < 40) begin
         if (BUSY) busy_cnt++;
         @(posedge CLK); #1;
         lat++;
         if (DONE) break;
      end
   endtask

   task automatic test_reset;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      vectors++;
      if ({BUSY, DONE, FOUND, INVERTED, IMM12} !== 16'h0) begin
         miscompares++;
         $display("FAIL reset: outputs=%h required=0000", {BUSY, DONE, FOUND, INVERTED, IMM12});
      end
      @(negedge CLK); RST = 1'b0;
   endtask

   task automatic test_direct;
      logic [31:0] vals [4] = '{32'h0000_00FF, 32'h0000_0000, 32'hFF00_0000, 32'hF000_000F};
      int          lats [4] = '{1, 1, 5, 3};
      logic [11:0] imms [4] = '{12'h0FF, 12'h000, 12'h4FF, 12'h2FF};
      int lat, bc;
      for (int i = 0; i < 4; i++) begin
         do_req(vals[i], 1'b0, lat, bc);
         vectors++;
         if (lat !== lats[i]) begin
            miscompares++;
            $display("FAIL direct_lat[%0d]: got=%0d required=%0d", i, lat, lats[i]);
         end
         vectors++;
         if ({FOUND, INVERTED, IMM12} !== {2'b10, imms[i]}) begin
            miscompares++;
            $display("FAIL direct_res[%0d]: got=%b/%b/%h required=1/0/%h", i, FOUND, INVERTED, IMM12, imms[i]);
         end
         @(posedge CLK); #1;
         vectors++;
         if ({DONE, FOUND, IMM12} !== {2'b01, imms[i]}) begin
            miscompares++;
            $display("FAIL done_pulse[%0d]: done=%b found=%b imm=%h required 0/1/%h", i, DONE, FOUND, IMM12, imms[i]);
         end
      end
   endtask

   task automatic test_fallback;
      int lat, bc;
      do_req(32'hFFFF_FF00, 1'b0, lat, bc);
      vectors++;
      if (lat !== 16 || {FOUND, INVERTED, IMM12} !== 14'h0) begin
         miscompares++;
         $display("FAIL miss_noinv: lat=%0d res=%b/%b/%h required 16/0/0/000", lat, FOUND, INVERTED, IMM12);
      end
      do_req(32'hFFFF_FF00, 1'b1, lat, bc);
      vectors++;
      if (lat !== 17 || {FOUND, INVERTED, IMM12} !== {2'b11, 12'h0FF}) begin
         miscompares++;
         $display("FAIL inv_hit: lat=%0d res=%b/%b/%h required 17/1/1/0ff", lat, FOUND, INVERTED, IMM12);
      end
      do_req(32'h0000_0101, 1'b1, lat, bc);
      vectors++;
      if (lat !== 32 || FOUND !== 1'b0 || IMM12 !== 12'h0) begin
         miscompares++;
         $display("FAIL total_miss: lat=%0d found=%b imm=%h required 32/0/000", lat, FOUND, IMM12);
      end
      vectors++;
      if (bc !== 32) begin
         miscompares++;
         $display("FAIL busy_len: got=%0d required=32", bc);
      end
   endtask

   task automatic test_ignore_while_busy;
      int lat;
      @(negedge CLK);
      VALUE = 32'hFF00_0000; TRY_INV = 1'b0; START = 1'b1;
      @(posedge CLK); #1;
      lat = 0;
      while (lat < 40) begin
         START = (lat % 2 == 0);
         VALUE = 32'h1234_5678 + 32'(lat);
         TRY_INV = 1'b1;
         @(posedge CLK); #1;
         lat++;
         if (DONE) break;
      end
      START = 1'b0;
      vectors++;
      if (lat !== 5 || {FOUND, INVERTED, IMM12} !== {2'b10, 12'h4FF}) begin
         miscompares++;
         $display("FAIL ignore_busy: lat=%0d res=%b/%b/%h required 5/1/0/4ff", lat, FOUND, INVERTED, IMM12);
      end
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge CLK);
      VALUE = 32'h0000_00FF; TRY_INV = 1'b0; START = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      vectors++;
      if (DONE !== 1'b1 || IMM12 !== 12'h0FF) begin
         miscompares++;
         $display("FAIL b2b_first: done=%b imm=%h required 1/0ff", DONE, IMM12);
      end
      VALUE = 32'hFF00_0000;
      @(posedge CLK); #1;
      vectors++;
      if ({BUSY, DONE, FOUND, IMM12} !== {3'b100, 12'h0}) begin
         miscompares++;
         $display("FAIL b2b_restart: busy=%b done=%b found=%b imm=%h required 1/0/0/000", BUSY, DONE, FOUND, IMM12);
      end
      START = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(posedge CLK); #1;
         lat++;
         if (DONE) break;
      end
      vectors++;
      if (lat !== 5 || {FOUND, IMM12} !== {1'b1, 12'h4FF}) begin
         miscompares++;
         $display("FAIL b2b_second: lat=%0d found=%b imm=%h required 5/1/4ff", lat, FOUND, IMM12);
      end
   endtask

   task automatic test_rst_abort;
      int lat, bc;
      bit saw_done;
      @(negedge CLK);
      VALUE = 32'h0000_0101; TRY_INV = 1'b1; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (8) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      vectors++;
      if ({BUSY, DONE, FOUND, INVERTED, IMM12} !== 16'h0) begin
         miscompares++;
         $display("FAIL rst_abort_out: outputs=%h required=0000", {BUSY, DONE, FOUND, INVERTED, IMM12});
      end
      @(negedge CLK); RST = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (DONE || BUSY) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL rst_abort_quiet: activity=1 required=0");
      end
      do_req(32'h0000_00FF, 1'b0, lat, bc);
      vectors++;
      if (lat !== 1 || {FOUND, INVERTED, IMM12} !== {2'b10, 12'h0FF}) begin
         miscompares++;
         $display("FAIL rst_recover: lat=%0d res=%b/%b/%h required 1/1/0/0ff", lat, FOUND, INVERTED, IMM12);
      end
   endtask

   task automatic test_random;
      logic [31:0] v;
      logic        t;
      logic [13:0] exp;
      int lat, bc, exp_lat;
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) begin
            v = ror32({24'h0, 8'($urandom)}, 2 * $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) v = ~v;
         end else begin
            v = $urandom;
         end
         t = 1'($urandom_range(0, 1));
         do_req(v, t, lat, bc);
         exp = ref_encode(v, t);
         if (!exp[13]) exp_lat = t ? 32 : 16;
         else if (exp[12]) exp_lat = 17 + int'(exp[11:8]);
         else exp_lat = 1 + int'(exp[11:8]);
         vectors++;
         if ({FOUND, INVERTED, IMM12} !== exp || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL random v=%h t=%b: got=%b/%b/%h lat=%0d required=%b/%b/%h lat=%0d",
                     v, t, FOUND, INVERTED, IMM12, lat, exp[13], exp[12], exp[11:0], exp_lat);
         end
         if (FOUND === 1'b1) begin
            vectors++;
            if (ror32({24'h0, IMM12[7:0]}, 2 * int'(IMM12[11:8])) !== (INVERTED ? ~v : v)) begin
               miscompares++;
               $display("FAIL invariant v=%h: imm=%h inv=%b", v, IMM12, INVERTED);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_fallback();
      test_ignore_while_busy();
      test_back_to_back();
      test_rst_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
